// File: rtl/mem_arb_2x1.sv
// mem_arb_2x1: two clients share one memory port.
// Requests are arbitrated with a 1-bit round-robin pointer and forwarded
// combinationally. The ID of each accepted request goes into an in-order FIFO,
// and responses are routed back to the client named at the FIFO head.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   c0_req_* / c1_req_*               client request streams (val/rdy/msg)
//   c0_resp_* / c1_resp_*             client response streams (val/rdy/msg)
//   mem_req_*                         shared memory request stream
//   mem_resp_*                        shared memory response stream
//   num_out                           outstanding request count
//   err                               sticky flag for a response with nothing outstanding
// p_max_out must be a power of two and at least 2.

`ifndef MEM_REQ
`define MEM_REQ(o_bits) logic [(3 + (o_bits) + 32 + 2 + 32) - 1:0]
`endif
`ifndef MEM_RESP
`define MEM_RESP(o_bits) logic [(3 + (o_bits) + 2 + 2 + 32) - 1:0]
`endif

module mem_arb_2x1 #(
  parameter type         t_req_msg  = `MEM_REQ(8),
  parameter type         t_resp_msg = `MEM_RESP(8),
  parameter int unsigned p_max_out  = 4
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic                        c0_req_val,
  output logic                        c0_req_rdy,
  input  t_req_msg                    c0_req_msg,
  output logic                        c0_resp_val,
  input  logic                        c0_resp_rdy,
  output t_resp_msg                   c0_resp_msg,

  input  logic                        c1_req_val,
  output logic                        c1_req_rdy,
  input  t_req_msg                    c1_req_msg,
  output logic                        c1_resp_val,
  input  logic                        c1_resp_rdy,
  output t_resp_msg                   c1_resp_msg,

  output logic                        mem_req_val,
  input  logic                        mem_req_rdy,
  output t_req_msg                    mem_req_msg,
  input  logic                        mem_resp_val,
  output logic                        mem_resp_rdy,
  input  t_resp_msg                   mem_resp_msg,

  output logic [$clog2(p_max_out):0]  num_out,
  output logic                        err
);

  localparam int unsigned AW = $clog2(p_max_out);
  localparam int unsigned CW = AW + 1;

  logic          r_ptr;
  logic          r_fifo [p_max_out];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_num_out;
  logic          r_err;

  logic w_full;
  logic w_empty;
  logic w_any_val;
  logic w_gnt;
  logic w_head;
  logic w_req_fire;
  logic w_resp_fire;

  // FIFO occupancy
  assign w_full  = (r_num_out == CW'(p_max_out));
  assign w_empty = (r_num_out == '0);

  // Request arbitration: the pointer only matters on a tie
  assign w_any_val = c0_req_val | c1_req_val;
  assign w_gnt     = (c0_req_val & c1_req_val) ? r_ptr : c1_req_val;

  assign mem_req_val = w_any_val & ~w_full & ~rst;
  assign mem_req_msg = w_gnt ? c1_req_msg : c0_req_msg;
  assign c0_req_rdy  = mem_req_val & mem_req_rdy & ~w_gnt;
  assign c1_req_rdy  = mem_req_val & mem_req_rdy &  w_gnt;
  assign w_req_fire  = mem_req_val & mem_req_rdy;

  // Response routing by the oldest outstanding ID; with nothing outstanding
  // the response is accepted and dropped
  assign w_head       = r_fifo[r_rd_ptr];
  assign mem_resp_rdy = rst     ? 1'b0 :
                        w_empty ? 1'b1 :
                        (w_head ? c1_resp_rdy : c0_resp_rdy);
  assign c0_resp_val  = ~rst & ~w_empty & mem_resp_val & ~w_head;
  assign c1_resp_val  = ~rst & ~w_empty & mem_resp_val &  w_head;
  assign c0_resp_msg  = mem_resp_msg;
  assign c1_resp_msg  = mem_resp_msg;
  assign w_resp_fire  = mem_resp_val & mem_resp_rdy & ~w_empty;

  assign num_out = r_num_out;
  assign err     = r_err;

  // Pointer, FIFO pointers, outstanding count and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_num_out <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_req_fire) begin
        r_ptr    <= ~r_ptr;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_resp_fire) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_req_fire && !w_resp_fire) begin
        r_num_out <= r_num_out + CW'(1);
      end else if (!w_req_fire && w_resp_fire) begin
        r_num_out <= r_num_out - CW'(1);
      end
      if (mem_resp_val && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  // ID storage; a stale entry is never read because the pointers are reset
  always_ff @(posedge clk) begin
    if (w_req_fire) begin
      r_fifo[r_wr_ptr] <= w_gnt;
    end
  end

endmodule

// File: tb/tb_mem_arb_2x1.sv
// Testbench for mem_arb_2x1: directed scenarios with a queue-based reference
// model checked on every negative clock edge, plus literal expectations.

`define CHK(nm, act, exp) chk(nm, 128'(act), 128'(exp))

module tb_mem_arb_2x1;

  localparam int MAX = 4;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } req_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } resp_t;

  localparam int REQW  = $bits(req_t);
  localparam int RESPW = $bits(resp_t);

  logic clk = 1'b0;
  logic rst;
  logic c0_req_val, c0_req_rdy, c0_resp_val, c0_resp_rdy;
  logic c1_req_val, c1_req_rdy, c1_resp_val, c1_resp_rdy;
  logic mem_req_val, mem_req_rdy, mem_resp_val, mem_resp_rdy;
  req_t  c0_req_msg, c1_req_msg, mem_req_msg;
  resp_t c0_resp_msg, c1_resp_msg, mem_resp_msg;
  logic [2:0] num_out;
  logic err;

  mem_arb_2x1 #(.t_req_msg(req_t), .t_resp_msg(resp_t), .p_max_out(MAX)) dut (
    .clk(clk), .rst(rst),
    .c0_req_val(c0_req_val), .c0_req_rdy(c0_req_rdy), .c0_req_msg(c0_req_msg),
    .c0_resp_val(c0_resp_val), .c0_resp_rdy(c0_resp_rdy), .c0_resp_msg(c0_resp_msg),
    .c1_req_val(c1_req_val), .c1_req_rdy(c1_req_rdy), .c1_req_msg(c1_req_msg),
    .c1_resp_val(c1_resp_val), .c1_resp_rdy(c1_resp_rdy), .c1_resp_msg(c1_resp_msg),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_msg(mem_req_msg),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_msg(mem_resp_msg),
    .num_out(num_out), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model: outstanding client IDs in issue order, tie-break
  // preference, sticky error
  bit mdl_q[$];
  bit mdl_ptr = 1'b0;
  bit mdl_err = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_step();
    bit win, pop, push, empty;
    if (rst) begin
      mdl_q.delete();
      mdl_ptr = 1'b0;
      mdl_err = 1'b0;
    end else begin
      empty = (mdl_q.size() == 0);
      win   = (c0_req_val && c1_req_val) ? mdl_ptr : c1_req_val;
      push  = (c0_req_val || c1_req_val) && (mdl_q.size() < MAX) && mem_req_rdy;
      pop   = mem_resp_val && !empty && (mdl_q[0] ? c1_resp_rdy : c0_resp_rdy);
      if (mem_resp_val && empty) mdl_err = 1'b1;
      if (pop) void'(mdl_q.pop_front());
      if (push) begin
        mdl_q.push_back(win);
        mdl_ptr = !mdl_ptr;
      end
    end
  endtask

  task automatic compare();
    bit win, e_mval, empty, head, e_mrr, e_c0v, e_c1v;
    win    = (c0_req_val && c1_req_val) ? mdl_ptr : c1_req_val;
    e_mval = !rst && (c0_req_val || c1_req_val) && (mdl_q.size() < MAX);
    empty  = (mdl_q.size() == 0);
    head   = empty ? 1'b0 : mdl_q[0];
    e_c0v  = 1'b0;
    e_c1v  = 1'b0;
    if (rst)        e_mrr = 1'b0;
    else if (empty) e_mrr = 1'b1;
    else begin
      e_mrr = head ? c1_resp_rdy : c0_resp_rdy;
      e_c0v = mem_resp_val && !head;
      e_c1v = mem_resp_val && head;
    end
    `CHK("mem_req_val", mem_req_val, e_mval);
    `CHK("c0_req_rdy", c0_req_rdy, e_mval && mem_req_rdy && !win);
    `CHK("c1_req_rdy", c1_req_rdy, e_mval && mem_req_rdy && win);
    `CHK("mem_resp_rdy", mem_resp_rdy, e_mrr);
    `CHK("c0_resp_val", c0_resp_val, e_c0v);
    `CHK("c1_resp_val", c1_resp_val, e_c1v);
    `CHK("num_out", num_out, mdl_q.size());
    `CHK("err", err, mdl_err);
    if (e_mval) `CHK("mem_req_msg", mem_req_msg, win ? c1_req_msg : c0_req_msg);
    if (e_c0v)  `CHK("c0_resp_msg", c0_resp_msg, mem_resp_msg);
    if (e_c1v)  `CHK("c1_resp_msg", c1_resp_msg, mem_resp_msg);
  endtask

  initial forever begin
    @(posedge clk);
    mdl_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      compare();
      n_vec++;
      if ((c0_req_rdy & c1_req_rdy) !== 1'b0) begin
        n_bad++;
        $display("FAIL both_req_rdy at %0t", $time);
      end
      if (rst) begin
        n_vec++;
        if ({mem_req_val, c0_req_rdy, c1_req_rdy, mem_resp_rdy, c0_resp_val, c1_resp_val} !== 6'b0) begin
          n_bad++;
          $display("FAIL rst_outputs at %0t", $time);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Return every outstanding response with both clients ready
  task automatic drain();
    c0_req_val  = 1'b0;
    c1_req_val  = 1'b0;
    c0_resp_rdy = 1'b1;
    c1_resp_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      mem_resp_val = (mdl_q.size() != 0);
      mem_resp_msg = RESPW'({$urandom(), $urandom()});
      step();
    end
    mem_resp_val = 1'b0;
    at_neg();
    `CHK("drain_num_out", num_out, 0);
    step();
  endtask

  int n0, n_acc;

  initial begin
    rst = 1'b1;
    c0_req_val = 1'b1; c1_req_val = 1'b0;
    c0_req_msg = '0; c1_req_msg = '0;
    c0_resp_rdy = 1'b0; c1_resp_rdy = 1'b0;
    mem_req_rdy = 1'b1; mem_resp_val = 1'b0; mem_resp_msg = '0;

    // Reset state, request outputs gated while in reset
    step();
    chk_en = 1'b1;
    at_neg();
    `CHK("rst_num_out", num_out, 0);
    `CHK("rst_err", err, 0);
    `CHK("rst_mem_req_val", mem_req_val, 0);
    `CHK("rst_c0_req_rdy", c0_req_rdy, 0);
    step();
    rst = 1'b0;
    c0_req_val = 1'b0;

    // Both clients always valid: grants alternate and split evenly
    c0_req_val = 1'b1; c1_req_val = 1'b1;
    c0_resp_rdy = 1'b1; c1_resp_rdy = 1'b1;
    n0 = 0;
    for (int i = 0; i < 100; i++) begin
      c0_req_msg   = REQW'({$urandom(), $urandom(), $urandom()});
      c1_req_msg   = REQW'({$urandom(), $urandom(), $urandom()});
      mem_resp_val = (mdl_q.size() != 0);
      mem_resp_msg = RESPW'({$urandom(), $urandom()});
      at_neg();
      if (c0_req_rdy) n0++;
      if (i < 4) `CHK("alt_grant", c1_req_rdy, i % 2);
      step();
    end
    `CHK("c0_share", n0, 50);
    drain();

    // c0 reads 0x100, then c1 reads 0x200; responses after three idle cycles
    c0_req_val = 1'b1;
    c0_req_msg = '{typ: 3'd0, opaque: 8'hA0, addr: 32'h100, len: 2'd0, data: 32'd0};
    at_neg();
    `CHK("c0_req_addr", mem_req_msg.addr, 32'h100);
    `CHK("c0_req_opaque", mem_req_msg.opaque, 8'hA0);
    step();
    c0_req_val = 1'b0;
    c1_req_val = 1'b1;
    c1_req_msg = '{typ: 3'd0, opaque: 8'hB1, addr: 32'h200, len: 2'd0, data: 32'd0};
    at_neg();
    `CHK("c1_req_addr", mem_req_msg.addr, 32'h200);
    `CHK("c1_req_rdy_lit", c1_req_rdy, 1);
    step();
    c1_req_val = 1'b0;
    step(); step(); step();
    mem_resp_val = 1'b1;
    mem_resp_msg = '{typ: 3'd0, opaque: 8'hA0, test: 2'd0, len: 2'd0, data: 32'hDEADBEEF};
    at_neg();
    `CHK("rsp0_c0_val", c0_resp_val, 1);
    `CHK("rsp0_c1_val", c1_resp_val, 0);
    `CHK("rsp0_data", c0_resp_msg.data, 32'hDEADBEEF);
    `CHK("rsp0_opaque", c0_resp_msg.opaque, 8'hA0);
    step();
    mem_resp_msg = '{typ: 3'd0, opaque: 8'hB1, test: 2'd0, len: 2'd0, data: 32'h12345678};
    at_neg();
    `CHK("rsp1_c1_val", c1_resp_val, 1);
    `CHK("rsp1_c0_val", c0_resp_val, 0);
    `CHK("rsp1_data", c1_resp_msg.data, 32'h12345678);
    `CHK("rsp1_opaque", c1_resp_msg.opaque, 8'hB1);
    step();
    mem_resp_val = 1'b0;

    // Six requests with no responses: only four accepted
    c0_req_val = 1'b1; c1_req_val = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      at_neg();
      if (c0_req_rdy || c1_req_rdy) n_acc++;
      step();
    end
    `CHK("full_accepts", n_acc, 4);
    at_neg();
    `CHK("full_num_out", num_out, 4);
    `CHK("full_c0_rdy", c0_req_rdy, 0);
    `CHK("full_c1_rdy", c1_req_rdy, 0);
    step();
    mem_resp_val = 1'b1;
    at_neg();
    `CHK("full_pop_no_unblock", mem_req_val, 0);
    `CHK("full_head_c0", c0_resp_val, 1);
    step();
    mem_resp_val = 1'b0;
    at_neg();
    `CHK("after_pop_num_out", num_out, 3);
    `CHK("after_pop_req_val", mem_req_val, 1);
    step();
    drain();

    // Head response stalled by c0 blocks c1's response behind it
    c0_req_val = 1'b1;
    step();
    c0_req_val = 1'b0;
    c1_req_val = 1'b1;
    step();
    c1_req_val = 1'b0;
    mem_resp_val = 1'b1;
    c0_resp_rdy  = 1'b0;
    mem_resp_msg = '{typ: 3'd0, opaque: 8'h0C, test: 2'd0, len: 2'd0, data: 32'hC0C0};
    for (int i = 0; i < 10; i++) begin
      at_neg();
      `CHK("stall_mem_resp_rdy", mem_resp_rdy, 0);
      `CHK("stall_c1_val", c1_resp_val, 0);
      step();
    end
    at_neg();
    `CHK("stall_num_out", num_out, 2);
    step();
    c0_resp_rdy = 1'b1;
    at_neg();
    `CHK("unstall_c0_val", c0_resp_val, 1);
    `CHK("unstall_c0_data", c0_resp_msg.data, 32'hC0C0);
    step();
    mem_resp_msg = '{typ: 3'd0, opaque: 8'h1C, test: 2'd0, len: 2'd0, data: 32'hC1C1};
    at_neg();
    `CHK("unstall_c1_val", c1_resp_val, 1);
    `CHK("unstall_c1_data", c1_resp_msg.data, 32'hC1C1);
    step();
    mem_resp_val = 1'b0;
    at_neg();
    `CHK("unstall_num_out", num_out, 0);
    step();

    // Unexpected response: dropped, sticky error until reset
    mem_resp_val = 1'b1;
    c0_resp_rdy = 1'b0;
    c1_resp_rdy = 1'b0;
    at_neg();
    `CHK("unexp_resp_rdy", mem_resp_rdy, 1);
    `CHK("unexp_c0_val", c0_resp_val, 0);
    `CHK("unexp_c1_val", c1_resp_val, 0);
    step();
    mem_resp_val = 1'b0;
    at_neg();
    `CHK("err_set", err, 1);
    step(); step();
    at_neg();
    `CHK("err_sticky", err, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    at_neg();
    `CHK("err_cleared", err, 0);
    step();

    // Reset with three outstanding: count cleared, pointer back to client 0
    c0_req_val = 1'b1;
    step(); step(); step();
    c0_req_val = 1'b0;
    at_neg();
    `CHK("pre_rst_num_out", num_out, 3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    c0_req_val = 1'b1;
    c1_req_val = 1'b1;
    at_neg();
    `CHK("post_rst_num_out", num_out, 0);
    `CHK("post_rst_c0_gnt", c0_req_rdy, 1);
    `CHK("post_rst_c1_gnt", c1_req_rdy, 0);
    step();
    at_neg();
    `CHK("post_rst_c1_next", c1_req_rdy, 1);
    step();
    drain();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arb_2x1.md
MEM_ARB_2X1 -- requirements
Module: mem_arb_2x1

Interface
REQ-001 SHALL have parameter t_req_msg, default `MEM_REQ(8), memory request message type.
REQ-002 SHALL have parameter t_resp_msg, default `MEM_RESP(8), memory response message type.
REQ-003 SHALL have parameter p_max_out, default 4, outstanding-request limit; power of two, >= 2.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have ports c0_req_val / c0_req_rdy / c0_req_msg: in / out / in, widths 1 / 1 / $bits(t_req_msg); client 0 request stream.
REQ-007 SHALL have ports c0_resp_val / c0_resp_rdy / c0_resp_msg: out / in / out, widths 1 / 1 / $bits(t_resp_msg); client 0 response stream.
REQ-008 SHALL have ports c1_req_* and c1_resp_*, identical to REQ-006/007, for client 1.
REQ-009 SHALL have ports mem_req_val / mem_req_rdy / mem_req_msg: out / in / out; single shared memory request stream.
REQ-010 SHALL have ports mem_resp_val / mem_resp_rdy / mem_resp_msg: in / out / in; shared memory response stream.
REQ-011 SHALL have port num_out, output, $clog2(p_max_out)+1 bits; current outstanding count.
REQ-012 SHALL have port err, output, 1; sticky flag for an unexpected response.

Function
REQ-013 SHALL forward request messages unmodified, including opaque, to mem_req_msg from the granted client; no added latency.
REQ-014 SHALL keep a 1-bit priority pointer; on a tie (both clients valid) it SHALL grant the client the pointer names.
REQ-015 SHALL flip the pointer to the other client only on a completed transfer (mem_req_val & mem_req_rdy); otherwise it holds.
REQ-016 SHALL grant the sole valid client when only one client is valid, regardless of the pointer.
REQ-017 SHALL drive mem_req_val = (c0_req_val | c1_req_val) & !full; it SHALL NOT depend on mem_req_rdy.
REQ-018 SHALL assert a client's req_rdy only when that client is granted, !full, and mem_req_rdy is high; the non-granted client's rdy SHALL be 0.
REQ-019 SHALL push the granted client ID into an in-order ID FIFO of depth p_max_out on every completed memory request.
REQ-020 SHALL treat full as num_out == p_max_out; a same-cycle response dequeue SHALL NOT unblock a request when full.
REQ-021 SHALL, while the FIFO is non-empty, route mem_resp_val/msg to the client named at the FIFO head; the other client's resp_val SHALL be 0.
REQ-022 SHALL drive mem_resp_rdy = resp_rdy of the client at the FIFO head.
REQ-023 SHALL pop the FIFO on mem_resp_val & mem_resp_rdy.
REQ-024 SHALL allow a push and a pop in the same cycle when not full; num_out is then unchanged.
REQ-025 SHALL wrap FIFO read/write pointers modulo p_max_out; num_out SHALL never exceed p_max_out or go negative.
REQ-026 SHALL, on mem_resp_val with the FIFO empty, drive mem_resp_rdy=1, drop the message, hold both client resp_val at 0, and set err=1 until reset.
REQ-027 SHALL keep request arbitration and response routing independent, so both handshakes can complete in one cycle.
REQ-028 SHALL hold a client's grant while its req_val is high and rdy is low, with no re-arbitration, provided the other client is not newly granted by a pointer change.

Reset
REQ-029 SHALL, when rst is high, set the pointer to client 0, empty the FIFO, and clear num_out and err; all val/rdy outputs SHALL be 0 during reset.
REQ-030 SHALL discard all outstanding IDs on reset mid-operation; a response arriving after reset is handled per REQ-026.

Verification
REQ-031 SHALL cover: both clients valid every cycle, mem_req_rdy=1 -> grants alternate c0,c1,c0,c1; each client gets 50% over 100 requests.
REQ-032 SHALL cover: c0 reads addr 0x100 (data 0xDEADBEEF), then c1 reads 0x200 (data 0x12345678), server delay 3 -> each response reaches only the issuing client, with opaque and addr intact.
REQ-033 SHALL cover: p_max_out=4, mem_resp held invalid, 6 requests issued -> exactly 4 accepted, num_out=4, both client rdy=0 until the first response pops.
REQ-034 SHALL cover: c0 resp_rdy=0 for 10 cycles with its response at the head -> mem_resp_rdy=0, c1 response stalls behind it, no data lost or reordered.
REQ-035 SHALL cover: mem_resp_val=1 with num_out=0 -> response dropped, err=1 sticky; then rst -> err=0.
REQ-036 SHALL cover: rst asserted with 3 outstanding -> num_out=0 next cycle, pointer=client 0, new requests accepted normally.
